// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the counter and the future async FIFO pointer logic.
package gray_pkg;

  localparam int GRAY_WIDTH_MAX = 16;

  function automatic logic [GRAY_WIDTH_MAX-1:0] bin2gray(input logic [GRAY_WIDTH_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decode: each binary bit is the XOR of all Gray bits at or above it.
module gray_to_bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign o_bin[i] = ^(i_gray >> i);
  end

endmodule

// File: rtl/gray_counter_n.sv
// Up/down Gray-code counter with synchronous load and a one-cycle wrap pulse.
// There is no handshake: gray/bin/wrap are registered and valid every cycle, one cycle after the controls are sampled.
module gray_counter_n
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             wrap
);

  if (WIDTH < 2 || WIDTH > GRAY_WIDTH_MAX) begin : g_width_check
    $error("gray_counter_n: WIDTH out of range 2..16");
  end

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             wrap_q;

  logic [WIDTH-1:0] w_load_bin;
  logic [WIDTH-1:0] w_bin_next;
  logic [WIDTH-1:0] w_gray_next;
  logic             w_wrap_next;

  gray_to_bin #(.WIDTH(WIDTH)) u_load_decode (
    .i_gray (load_gray),
    .o_bin  (w_load_bin)
  );

  // Gray is always re-encoded from the next binary value, so it can never drift from bin.
  always_comb begin
    w_bin_next  = bin_q;
    w_wrap_next = 1'b0;
    if (load) begin
      w_bin_next = w_load_bin;
    end else if (en) begin
      if (up) begin
        w_bin_next  = bin_q + WIDTH'(1);
        w_wrap_next = &bin_q;
      end else begin
        w_bin_next  = bin_q - WIDTH'(1);
        w_wrap_next = ~|bin_q;
      end
    end
    w_gray_next = load ? load_gray : WIDTH'(bin2gray(GRAY_WIDTH_MAX'(w_bin_next)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= w_bin_next;
      gray_q <= w_gray_next;
      wrap_q <= w_wrap_next;
    end
  end

  assign gray = gray_q;
  assign bin  = bin_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter_n.sv
// Bench for gray_counter_n: directed WIDTH=4 scenarios plus a randomized WIDTH=6 run, both scoreboarded.
module tb_gray_counter_n;

  localparam int EW = 34;  // {step, wrap, bin[15:0], gray[15:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, en4, up4, load4, wrap4;
  logic [3:0] lg4, gray4, bin4;
  logic       rst6, en6, up6, load6, wrap6;
  logic [5:0] lg6, gray6, bin6;

  gray_counter_n #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .en(en4), .up(up4), .load(load4),
    .load_gray(lg4), .gray(gray4), .bin(bin4), .wrap(wrap4)
  );

  gray_counter_n #(.WIDTH(6)) dut6 (
    .clk(clk), .rst(rst6), .en(en6), .up(up6), .load(load6),
    .load_gray(lg6), .gray(gray6), .bin(bin6), .wrap(wrap6)
  );

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q4[$];
  logic [EW-1:0] exp_q6[$];
  int m4 = 0;
  int m6 = 0;
  int wraps_model6 = 0;
  int wraps_dut6 = 0;
  logic [5:0] prev6 = '0;

  // ---------------- reference model ----------------
  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int from_gray(input int w, input int g);
    for (int b = 0; b < (1 << w); b++) if (to_gray(b) == g) return b;
    return 0;
  endfunction

  task automatic model(input int w, input int s, input bit e, input bit u, input bit l,
                       input int lg, output int ns, output bit wr, output bit step);
    int modulus;
    modulus = 1 << w;
    wr = 1'b0;
    step = 1'b0;
    ns = s;
    if (l) begin
      ns = from_gray(w, lg);
    end else if (e) begin
      step = 1'b1;
      if (u) begin
        ns = (s + 1) % modulus;
        wr = (s == modulus - 1);
      end else begin
        ns = (s + modulus - 1) % modulus;
        wr = (s == 0);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive4(input bit e, input bit u, input bit l, input int lg);
    int ns;
    bit wr, st;
    @(negedge clk);
    en4 = e; up4 = u; load4 = l; lg4 = 4'(lg);
    model(4, m4, e, u, l, lg, ns, wr, st);
    m4 = ns;
    exp_q4.push_back({1'b0, wr, 16'(ns), 16'(to_gray(ns))});
    @(posedge clk);
    #2;
    en4 = 1'b0; load4 = 1'b0;
  endtask

  task automatic drive6(input bit e, input bit u, input bit l, input int lg);
    int ns;
    bit wr, st;
    @(negedge clk);
    en6 = e; up6 = u; load6 = l; lg6 = 6'(lg);
    model(6, m6, e, u, l, lg, ns, wr, st);
    m6 = ns;
    if (wr) wraps_model6++;
    exp_q6.push_back({st, wr, 16'(ns), 16'(to_gray(ns))});
    @(posedge clk);
    #2;
    en6 = 1'b0; load6 = 1'b0;
  endtask

  // ---------------- scoreboard monitors ----------------
  logic [EW-1:0] e4, e6;

  always begin
    @(posedge clk);
    #1;
    if (exp_q4.size() > 0) begin
      e4 = exp_q4.pop_front();
      check("sb4_gray", gray4, e4[15:0]);
      check("sb4_bin", bin4, e4[31:16]);
      check("sb4_wrap", wrap4, e4[32]);
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (exp_q6.size() > 0) begin
      e6 = exp_q6.pop_front();
      check("sb6_gray", gray6, e6[15:0]);
      check("sb6_bin", bin6, e6[31:16]);
      check("sb6_wrap", wrap6, e6[32]);
      check("inv6_gray_of_bin", gray6, to_gray(int'(bin6)));
      if (e6[33]) check("inv6_one_bit_step", $countones(gray6 ^ prev6), 1);
      prev6 = gray6;
      if (wrap6 === 1'b1) wraps_dut6++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic seq4();
    int sc1[16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
    for (int k = 0; k < 16; k++) begin
      drive4(1, 1, 0, 0);
      check("sc1_gray", gray4, sc1[k]);
      check("sc1_wrap", wrap4, (k == 15) ? 1 : 0);
    end
    @(negedge clk); rst4 = 1'b1; m4 = 0;
    @(negedge clk); rst4 = 1'b0;
    drive4(1, 0, 0, 0);
    check("sc2_gray", gray4, 8); check("sc2_bin", bin4, 15); check("sc2_wrap", wrap4, 1);
    drive4(1, 0, 0, 0);
    check("sc2b_gray", gray4, 9); check("sc2b_bin", bin4, 14); check("sc2b_wrap", wrap4, 0);
    drive4(1, 1, 1, 12);
    check("sc3_gray", gray4, 12); check("sc3_bin", bin4, 8); check("sc3_wrap", wrap4, 0);
    drive4(1, 1, 0, 0);
    check("sc3b_gray", gray4, 13); check("sc3b_bin", bin4, 9);
    drive4(0, 1, 1, 5);
    for (int k = 0; k < 5; k++) begin
      drive4(0, 1, 0, 0);
      check("sc4_gray", gray4, 5); check("sc4_bin", bin4, 6); check("sc4_wrap", wrap4, 0);
    end
    drive4(0, 1, 1, 8);
    check("load_max_wrap", wrap4, 0); check("load_max_bin", bin4, 15);
    drive4(1, 1, 0, 0);
    check("wrap_after_load_gray", gray4, 0); check("wrap_after_load", wrap4, 1);
    drive4(0, 1, 1, 14);
    check("sc5_pre_bin", bin4, 11);
    #1 rst4 = 1'b1;
    #1;
    check("sc5_async_gray", gray4, 0); check("sc5_async_bin", bin4, 0); check("sc5_async_wrap", wrap4, 0);
    m4 = 0;
    @(negedge clk); rst4 = 1'b0;
    drive4(1, 1, 0, 0);
    check("sc5_resume_gray", gray4, 1); check("sc5_resume_wrap", wrap4, 0);
    repeat (200) drive4($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                        $urandom_range(0, 7) == 0, int'($urandom_range(0, 15)));
  endtask

  task automatic rand6();
    repeat (10000) drive6($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 15) == 0, int'($urandom_range(0, 63)));
  endtask

  initial begin
    rst4 = 1'b1; en4 = 1'b0; up4 = 1'b1; load4 = 1'b0; lg4 = '0;
    rst6 = 1'b1; en6 = 1'b0; up6 = 1'b1; load6 = 1'b0; lg6 = '0;
    repeat (2) @(negedge clk);
    check("rst4_gray", gray4, 0); check("rst4_bin", bin4, 0); check("rst4_wrap", wrap4, 0);
    check("rst6_gray", gray6, 0); check("rst6_bin", bin6, 0); check("rst6_wrap", wrap6, 0);
    rst4 = 1'b0; rst6 = 1'b0;
    fork
      seq4();
      rand6();
    join
    repeat (3) @(posedge clk);
    #3;
    check("q4_drained", exp_q4.size(), 0);
    check("q6_drained", exp_q6.size(), 0);
    check("wrap6_count", wraps_dut6, wraps_model6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_counter_n.md
# gray_counter_n

Parametrised Gray-code counter with up/down direction, count enable, synchronous parallel load and wrap indication. It is the general-purpose successor to the fixed 4-bit Gray-code state-machine counter, for any width. Typical uses are pointer generation for clock-domain-crossing FIFOs and glitch-free multi-bit state outputs. The Gray output changes exactly one bit per count step, so it can be sampled by another clock domain.

## Interface

Parameters:
- `WIDTH`, default 4: counter width in bits. Legal range is 2..16.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `en`, input, 1: count enable. Advances the counter by one step per cycle while high.
- `up`, input, 1: direction, sampled when `en`=1. 1 = increment, 0 = decrement.
- `load`, input, 1: synchronous load strobe.
- `load_gray`, input, WIDTH: value to load, Gray-encoded.
- `gray`, output, WIDTH: registered Gray-code count.
- `bin`, output, WIDTH: registered binary equivalent of `gray`.
- `wrap`, output, 1: registered one-cycle pulse on modulo wrap.

## Operation

- State is held in two registers: binary `bin_q` and Gray `gray_q`. `gray_q` always equals `bin_q ^ (bin_q >> 1)`. Both registers drive the outputs directly, with no combinational output logic.
- Priority on each rising edge: `rst` > `load` > `en` > hold.
- Load: `bin_q` <= gray_to_bin(`load_gray`) and `gray_q` <= `load_gray`. `wrap` is 0 on a load, even if the loaded value is 0 or the maximum.
- Count up (`en`=1, `up`=1): `bin_q` <= `bin_q` + 1, modulo 2^WIDTH.
- Count down (`en`=1, `up`=0): `bin_q` <= `bin_q` − 1, modulo 2^WIDTH.
- Hold (`en`=0, `load`=0): all state is unchanged and `wrap` is 0.
- Wrap conditions:
  - `wrap` is set to 1 when an up-count moves from 2^WIDTH−1 to 0.
  - `wrap` is set to 1 when a down-count moves from 0 to 2^WIDTH−1.
  - `wrap` is 0 in every other cycle.
- The next-state `gray_q` is computed from the next-state binary value, not by incrementing in Gray space.
- Direction may change on any cycle. Each step still changes `gray` by exactly one bit.
- Reset values: `gray`=0, `bin`=0, `wrap`=0. Reset takes effect immediately, without waiting for a clock edge.
- Reset mid-operation: state returns to 0. Counting resumes from 0 on the first enabled edge after `rst` is released.
- Release of `rst` is synchronised externally. The block does not guarantee behaviour if `rst` falls within setup/hold of `clk`.

## Timing

- Latency is 1 cycle. A control input sampled on edge N is visible on `gray`, `bin` and `wrap` after edge N.
- `wrap` asserts in the same cycle that `gray`/`bin` first show the wrapped value, and lasts exactly one cycle per wrap event.
- Continuous counting (`en` held high): one step per cycle, no bubbles. The full sequence repeats every 2^WIDTH cycles.
- All inputs are synchronous to `clk`.
- Critical path: WIDTH-bit add/subtract, then XOR encode, into `gray_q`. The load path goes through a WIDTH-deep XOR prefix chain in the `load_gray` decode.

## Structure

- Shared package/include `gray_pkg` contains:
  - function `bin2gray(b)` = b ^ (b >> 1)
  - constant `GRAY_WIDTH_MAX` = 16
  - These are reused by the future async FIFO pointer logic.
- One sub-module, `gray_to_bin`:
  - combinational, parametrised by `WIDTH`
  - b[WIDTH−1] = g[WIDTH−1]; b[i] = b[i+1] ^ g[i]
  - instantiated on `load_gray`
- Top level: one always block with async reset for `bin_q`, `gray_q` and `wrap_q`, plus the next-state logic.

## Test plan

All scenarios use `WIDTH`=4 unless stated otherwise.

1. Reset, then `en`=1, `up`=1 for 16 cycles:
   - `gray` sequence: 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then 0000.
   - `wrap`=1 only in the 0000 cycle after 1000.
2. From reset, `en`=1, `up`=0 for one cycle:
   - `gray`=1000, `bin`=15, `wrap`=1.
   - Next down step: `gray`=1001, `bin`=14, `wrap`=0.
3. `load`=1 with `load_gray`=1100, and `en`=1 in the same cycle:
   - Load wins: `gray`=1100, `bin`=8, `wrap`=0.
   - Next `en`/`up`=1 step: `gray`=1101, `bin`=9.
4. `en`=0 for 5 cycles at `bin`=6: outputs hold at `gray`=0101, `bin`=6, `wrap`=0.
5. Assert `rst` asynchronously, mid-cycle, at `bin`=11:
   - Outputs go to 0 before the next clock edge.
   - After release with `en`=1, the first value is `gray`=0001.
6. `WIDTH`=6, random `en`/`up`/`load` for 10,000 cycles, checked against a scoreboard:
   - `gray` == bin2gray(`bin`) every cycle.
   - Popcount(gray change) == 1 on every non-load step.
   - `wrap` count matches the model.
